// File: rtl/bcd_chain_ctrl_pkg.sv
// Shared definitions for the BCD chain controller.
//   state_e  : run-control FSM states (ST_IDLE, ST_RUN, ST_STOP, ST_OVF)
//   DIGIT_W  : width of one BCD digit
//   BCD_NINE : largest legal digit value
//   bcd_inc  : one-decade increment with roll-over from 9 to 0
package bcd_chain_ctrl_pkg;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_OVF  = 2'd3
    } state_e;

    // Any value at or above 9 rolls to 0 so a digit can never leave 0..9.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_NINE) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_chain_ctrl_digit.sv
// One decade of the BCD counter chain.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (digit -> 0)
//   en_i     : increment this digit on the coming edge
//   clr_i    : synchronous clear to 0, wins over en_i
//   q_o      : current digit value 0..9
//   carry_o  : this digit rolls over on the coming edge (q==9 and enabled)
module bcd_chain_ctrl_digit
    import bcd_chain_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               clr_i,
    output logic [DIGIT_W-1:0] q_o,
    output logic               carry_o
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i)
            q_d = '0;
        else if (en_i)
            q_d = bcd_inc(q_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o     = q_q;
    assign carry_o = (q_q == BCD_NINE) && en_i;

endmodule

// File: rtl/bcd_chain_ctrl.sv
// Run-control sequencer for a cascade of NDIGITS BCD digit counters with a
// prescaled count tick and a time-multiplexed display scan.
// Optional feature macro: BCD_LAP_HOLD_EN (adds the lap port and a hold
// register that can freeze the scanned display while counting continues).
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : IDLE/STOP -> RUN
//   stop       : RUN -> STOP (count and prescaler kept)
//   clear      : synchronous return to IDLE with all digits 0
//   lap        : (BCD_LAP_HOLD_EN only) toggles display hold on rising edge in RUN
//   count_bcd  : live count, digit k at [4k+3:4k]
//   scan_an    : one-hot active-high digit select
//   scan_digit : BCD value of the selected digit
//   running    : high while in RUN
//   tick       : high in the cycle whose closing edge increments the count
//   overflow   : 1-cycle pulse on wrap (WRAP=1) or held in OVF (WRAP=0)
module bcd_chain_ctrl
    import bcd_chain_ctrl_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int DIV      = 10,
    parameter int SCAN_DIV = 1000,
    parameter int WRAP     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
`ifdef BCD_LAP_HOLD_EN
    input  logic                       lap,
`endif
    output logic [DIGIT_W*NDIGITS-1:0] count_bcd,
    output logic [NDIGITS-1:0]         scan_an,
    output logic [DIGIT_W-1:0]         scan_digit,
    output logic                       running,
    output logic                       tick,
    output logic                       overflow
);

    localparam int PW  = $clog2(DIV);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    state_e         state_q;
    logic [PW-1:0]  presc_q;
    logic           running_q;
    logic           overflow_q;

    logic [DIGIT_W-1:0] digit_q [NDIGITS];
    logic [NDIGITS-1:0] en;
    logic [NDIGITS-1:0] carry;
    logic               all9;
    logic               inc;

    // ---------------- digit chain ----------------
    always_comb begin
        all9 = 1'b1;
        for (int k = 0; k < NDIGITS; k++)
            if (digit_q[k] != BCD_NINE)
                all9 = 1'b0;
    end

    assign tick = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));
    // Saturating build must not roll the chain over at all-9s.
    assign inc  = tick && ((WRAP != 0) || !all9);

    for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
        if (k == 0) begin : g_lsd
            assign en[k] = inc;
        end else begin : g_upper
            // Ripple: digit k moves only when every lower digit rolls over.
            assign en[k] = carry[k-1];
        end

        bcd_chain_ctrl_digit u_digit (
            .clk     (clk),
            .rst_n   (rst),
            .en_i    (en[k]),
            .clr_i   (clear),
            .q_o     (digit_q[k]),
            .carry_o (carry[k])
        );

        assign count_bcd[DIGIT_W*k +: DIGIT_W] = digit_q[k];
    end

    // ---------------- run-control FSM and prescaler ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_STOP: begin
                    overflow_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Prescaler pauses on the stop edge so resume finishes the period.
                    if (tick)
                        presc_q <= '0;
                    else if (!stop)
                        presc_q <= presc_q + PW'(1);

                    overflow_q <= tick && all9;

                    if (stop) begin
                        state_q   <= ST_STOP;
                        running_q <= 1'b0;
                    end else if (tick && all9 && (WRAP == 0)) begin
                        state_q   <= ST_OVF;
                        running_q <= 1'b0;
                    end
                end
                ST_OVF: begin
                    overflow_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign running  = running_q;
    assign overflow = overflow_q;

    // ---------------- display source ----------------
    logic [DIGIT_W-1:0] disp_digit [NDIGITS];

`ifdef BCD_LAP_HOLD_EN
    logic                       lap_q;
    logic                       lap_sel_q;
    logic [DIGIT_W*NDIGITS-1:0] hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_q     <= 1'b0;
            lap_sel_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            lap_q <= lap;
            if (clear) begin
                lap_sel_q <= 1'b0;
            end else if (lap && !lap_q && (state_q == ST_RUN)) begin
                if (lap_sel_q) begin
                    lap_sel_q <= 1'b0;
                end else begin
                    lap_sel_q <= 1'b1;
                    hold_q    <= count_bcd;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NDIGITS; k++)
            disp_digit[k] = lap_sel_q ? hold_q[DIGIT_W*k +: DIGIT_W] : digit_q[k];
    end
`else
    always_comb begin
        for (int k = 0; k < NDIGITS; k++)
            disp_digit[k] = digit_q[k];
    end
`endif

    // ---------------- display scan ----------------
    logic [SCW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]      scan_idx_q, scan_idx_d;
    logic [NDIGITS-1:0] scan_an_q, scan_an_d;
    logic [DIGIT_W-1:0] scan_digit_q, scan_digit_d;
    logic               scan_step;

    always_comb begin
        scan_step    = (scan_cnt_q == SCW'(SCAN_DIV - 1));
        scan_cnt_d   = scan_cnt_q + SCW'(1);
        scan_idx_d   = scan_idx_q;
        scan_an_d    = scan_an_q;
        scan_digit_d = scan_digit_q;
        if (scan_step) begin
            scan_cnt_d   = '0;
            scan_idx_d   = (scan_idx_q == IW'(NDIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
            // Select and value are sampled together so they never disagree.
            scan_an_d    = NDIGITS'(1) << scan_idx_d;
            scan_digit_d = disp_digit[scan_idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q   <= '0;
            scan_idx_q   <= '0;
            scan_an_q    <= NDIGITS'(1);
            scan_digit_q <= '0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            scan_an_q    <= scan_an_d;
            scan_digit_q <= scan_digit_d;
        end
    end

    assign scan_an    = scan_an_q;
    assign scan_digit = scan_digit_q;

endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// Bench for bcd_chain_ctrl with NDIGITS=2, DIV=4, SCAN_DIV=2.
// Two instances share stimulus: u_w1 wraps at 99, u_w0 saturates in OVF.
// Every tick of u_w1 is checked against a queue of expected pre-increment counts.
module tb_bcd_chain_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic lap = 1'b0;

    logic [7:0] w1_cnt, w0_cnt;
    logic [1:0] w1_an, w0_an;
    logic [3:0] w1_dig, w0_dig;
    logic       w1_run, w0_run, w1_tick, w0_tick, w1_ovf, w0_ovf;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    bcd_chain_ctrl #(.NDIGITS(2), .DIV(4), .SCAN_DIV(2), .WRAP(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
`ifdef BCD_LAP_HOLD_EN
        .lap(lap),
`endif
        .count_bcd(w1_cnt), .scan_an(w1_an), .scan_digit(w1_dig),
        .running(w1_run), .tick(w1_tick), .overflow(w1_ovf)
    );

    bcd_chain_ctrl #(.NDIGITS(2), .DIV(4), .SCAN_DIV(2), .WRAP(0)) u_w0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
`ifdef BCD_LAP_HOLD_EN
        .lap(lap),
`endif
        .count_bcd(w0_cnt), .scan_an(w0_an), .scan_digit(w0_dig),
        .running(w0_run), .tick(w0_tick), .overflow(w0_ovf)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each tick presents the count about to be incremented.
    always @(negedge clk) begin
        if (rst && w1_tick) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_tick unexpected tick actual=%0h required=none", w1_cnt);
            end else begin
                chk("sb_tick", w1_cnt, exp_q.pop_front());
            end
        end
    end

    initial begin
        // 1. reset state and free-running scan
        cyc(2);
        chk("rst_cnt",  w1_cnt, 8'h00);
        chk("rst_run",  w1_run, 1'b0);
        chk("rst_tick", w1_tick, 1'b0);
        chk("rst_ovf",  w1_ovf, 1'b0);
        chk("rst_an",   w1_an, 2'b01);
        chk("rst_dig",  w1_dig, 4'd0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_an", w1_an, (((i + 1) / 2) % 2) ? 2'b10 : 2'b01);
            chk("idle_tick", w1_tick, 1'b0);
        end
        cyc(1);

        // 2. 48 cycles of RUN -> 12 ticks
        for (int v = 0; v < 12; v++) exp_q.push_back(to_bcd(v));
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("run_rise", w1_run, 1'b1);
        cyc(48);
        chk("cnt12_w1", w1_cnt, 8'h12);
        chk("cnt12_w0", w0_cnt, 8'h12);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_run", w1_run, 1'b0);
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("scan12", {w1_an, w1_dig}, (w1_an == 2'b01) ? {2'b01, 4'd2} : {2'b10, 4'd1});
        end
        cyc(1);
        chk("stop_hold", w1_cnt, 8'h12);

        // 3. stop with prescaler at 2, resume finishes the partial period
        exp_q.push_back(8'h12);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(20);
        chk("pause_cnt", w1_cnt, 8'h12);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("resume_notick", w1_tick, 1'b0);
        cyc(1);
        chk("resume_tick", w1_tick, 1'b1);
        cyc(1);
        chk("resume_cnt", w1_cnt, 8'h13);

        // 4. run up to 99 and past it
        for (int v = 13; v <= 99; v++) exp_q.push_back(to_bcd(v));
        cyc(347);
        chk("at99_w1", w1_cnt, 8'h99);
        chk("at99_w0", w0_cnt, 8'h99);
        chk("at99_tick0", w0_tick, 1'b1);
        cyc(1);
        chk("wrap_cnt", w1_cnt, 8'h00);
        chk("wrap_ovf", w1_ovf, 1'b1);
        chk("wrap_run", w1_run, 1'b1);
        chk("sat_cnt",  w0_cnt, 8'h99);
        chk("sat_ovf",  w0_ovf, 1'b1);
        chk("sat_run",  w0_run, 1'b0);
        chk("sat_tick", w0_tick, 1'b0);
        cyc(1);
        chk("wrap_pulse", w1_ovf, 1'b0);
        chk("wrap_run2",  w1_run, 1'b1);
        chk("sat_hold",   w0_ovf, 1'b1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("ovf_start_run", w0_run, 1'b0);
        chk("ovf_start_cnt", w0_cnt, 8'h99);
        chk("ovf_start_ovf", w0_ovf, 1'b1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clr_cnt_w0", w0_cnt, 8'h00);
        chk("clr_ovf_w0", w0_ovf, 1'b0);
        chk("clr_run_w0", w0_run, 1'b0);
        chk("clr_cnt_w1", w1_cnt, 8'h00);
        chk("clr_run_w1", w1_run, 1'b0);

        // 5. clear wins over stop and start
        for (int v = 0; v < 37; v++) exp_q.push_back(to_bcd(v));
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(148);
        chk("cnt37", w1_cnt, 8'h37);
        start = 1'b1; stop = 1'b1; clear = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        chk("prio_cnt", w1_cnt, 8'h00);
        chk("prio_run", w1_run, 1'b0);
        cyc(6);
        chk("prio_idle_cnt", w1_cnt, 8'h00);
        chk("prio_idle_run", w1_run, 1'b0);

        // asynchronous reset in the middle of a prescaler period
        exp_q.push_back(8'h00);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(6);
        chk("pre_rst_cnt", w1_cnt, 8'h01);
        #2 rst = 1'b0;
        #1;
        chk("arst_cnt",  w1_cnt, 8'h00);
        chk("arst_run",  w1_run, 1'b0);
        chk("arst_tick", w1_tick, 1'b0);
        chk("arst_ovf",  w1_ovf, 1'b0);
        chk("arst_an",   w1_an, 2'b01);
        chk("arst_dig",  w1_dig, 4'd0);
        cyc(1);
        rst = 1'b1;
        cyc(8);
        chk("post_rst_cnt", w1_cnt, 8'h00);
        chk("post_rst_run", w1_run, 1'b0);

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
